// File: rtl/alu_seq_if.sv
// Handshaked operand/result bundle for alu_seq: valid/ready request in, valid/ready result out.
interface alu_seq_if #(parameter int WIDTH = 8) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [2:0]       alu_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_out;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             odd_parity;
    logic             busy;

    modport master (
        output in_valid, in1, in2, alu_op, out_ready,
        input  in_ready, out_valid, alu_out, carry, overflow, zero, odd_parity, busy
    );

    modport slave (
        input  in_valid, in1, in2, alu_op, out_ready,
        output in_ready, out_valid, alu_out, carry, overflow, zero, odd_parity, busy
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith ops plus an iterative shift-add multiply,
// with a depth-1 registered result slot carrying carry/overflow/zero/parity flags.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic   clk,
    input  logic   rst_n,
    alu_seq_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [2:0] OP_NOP = 3'b000, OP_ADD = 3'b001, OP_SUB = 3'b010, OP_AND = 3'b011,
                           OP_OR  = 3'b100, OP_NOT = 3'b101, OP_XOR = 3'b110, OP_MUL = 3'b111;

    typedef enum logic {S_IDLE, S_MUL} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0]   res_q, res_d;
    logic               c_q, v_q, z_q, p_q, c_d, v_d, z_d, p_d;
    logic               ov_q;
    logic [2*WIDTH-1:0] acc, mcand, acc_step;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     sum;
    logic               in_ready, in_fire, out_fire, mul_start, mul_last, load, fresh;

    assign in_ready  = (state == S_IDLE) && (!ov_q || bus.out_ready);
    assign in_fire   = bus.in_valid && in_ready;
    assign out_fire  = ov_q && bus.out_ready;
    assign mul_start = in_fire && (bus.alu_op == OP_MUL);
    assign mul_last  = (state == S_MUL) && (cnt == CW'(WIDTH - 1));
    assign acc_step  = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (mul_start) state_nxt = S_MUL;
            S_MUL:   if (mul_last)  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOP still loads the slot (a response is owed) but leaves value and flags untouched.
    always_comb begin
        res_d = res_q;
        c_d   = c_q;
        v_d   = v_q;
        z_d   = z_q;
        p_d   = p_q;
        sum   = '0;
        load  = 1'b0;
        fresh = 1'b0;
        if (mul_last) begin
            load  = 1'b1;
            fresh = 1'b1;
            res_d = acc_step[WIDTH-1:0];
            c_d   = |acc_step[2*WIDTH-1:WIDTH];
            v_d   = |acc_step[2*WIDTH-1:WIDTH];
        end else if (in_fire && bus.alu_op != OP_MUL) begin
            load  = 1'b1;
            fresh = (bus.alu_op != OP_NOP);
            case (bus.alu_op)
                OP_ADD: begin
                    sum   = {1'b0, bus.in1} + {1'b0, bus.in2};
                    res_d = sum[WIDTH-1:0];
                    c_d   = sum[WIDTH];
                    v_d   = (bus.in1[WIDTH-1] == bus.in2[WIDTH-1]) && (sum[WIDTH-1] != bus.in1[WIDTH-1]);
                end
                OP_SUB: begin
                    res_d = bus.in1 - bus.in2;
                    c_d   = bus.in1 < bus.in2;
                    v_d   = (bus.in1[WIDTH-1] != bus.in2[WIDTH-1]) && (res_d[WIDTH-1] != bus.in1[WIDTH-1]);
                end
                OP_AND:  begin res_d = bus.in1 & bus.in2; c_d = 1'b0; v_d = 1'b0; end
                OP_OR:   begin res_d = bus.in1 | bus.in2; c_d = 1'b0; v_d = 1'b0; end
                OP_NOT:  begin res_d = ~bus.in1;          c_d = 1'b0; v_d = 1'b0; end
                OP_XOR:  begin res_d = bus.in1 ^ bus.in2; c_d = 1'b0; v_d = 1'b0; end
                default: ;
            endcase
        end
        if (fresh) begin
            z_d = ~|res_d;
            p_d = ^res_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_q   <= 1'b0;
            res_q  <= '0;
            c_q    <= 1'b0;
            v_q    <= 1'b0;
            z_q    <= 1'b0;
            p_q    <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            if (load)          ov_q <= 1'b1;
            else if (out_fire) ov_q <= 1'b0;
            if (load) begin
                res_q <= res_d;
                c_q   <= c_d;
                v_q   <= v_d;
                z_q   <= z_d;
                p_q   <= p_d;
            end
            if (mul_start) begin
                mcand  <= {{WIDTH{1'b0}}, bus.in1};
                mplier <= bus.in2;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == S_MUL) begin
                acc    <= acc_step;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = ov_q;
    assign bus.alu_out    = res_q;
    assign bus.carry      = c_q;
    assign bus.overflow   = v_q;
    assign bus.zero       = z_q;
    assign bus.odd_parity = p_q;
    assign bus.busy       = (state == S_MUL);
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: WIDTH=8 instance for the main sequence, WIDTH=16 for the wide add.
module tb_alu_seq;
    localparam logic [2:0] OP_NOP = 3'b000, OP_ADD = 3'b001, OP_SUB = 3'b010, OP_AND = 3'b011,
                           OP_OR  = 3'b100, OP_NOT = 3'b101, OP_XOR = 3'b110, OP_MUL = 3'b111;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(8))  b8  ();
    alu_seq_if #(.WIDTH(16)) b16 ();

    alu_seq #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(b8));
    alu_seq #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        b8.alu_op   = op;
        b8.in1      = a;
        b8.in2      = b;
        b8.in_valid = 1'b1;
        #1;
        chk("send_in_ready", 32'(b8.in_ready), 1);
        tick();
        b8.in_valid = 1'b0;
    endtask

    task automatic flags8(input string tag, input logic [7:0] r, input logic c, input logic v,
                          input logic z, input logic p);
        chk({tag, "_valid"}, 32'(b8.out_valid), 1);
        chk({tag, "_out"},   32'(b8.alu_out), 32'(r));
        chk({tag, "_carry"}, 32'(b8.carry), 32'(c));
        chk({tag, "_ovf"},   32'(b8.overflow), 32'(v));
        chk({tag, "_zero"},  32'(b8.zero), 32'(z));
        chk({tag, "_par"},   32'(b8.odd_parity), 32'(p));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        b8.in_valid  = 1'b0; b8.in1  = '0; b8.in2  = '0; b8.alu_op  = OP_NOP; b8.out_ready  = 1'b1;
        b16.in_valid = 1'b0; b16.in1 = '0; b16.in2 = '0; b16.alu_op = OP_NOP; b16.out_ready = 1'b1;
        #12;
        chk("rst_valid", 32'(b8.out_valid), 0);
        chk("rst_out",   32'(b8.alu_out), 0);
        chk("rst_flags", {28'd0, b8.carry, b8.overflow, b8.zero, b8.odd_parity}, 0);
        chk("rst_busy",  32'(b8.busy), 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(b8.in_ready), 1);
        tick();

        send8(OP_ADD, 8'd12, 8'd11);
        flags8("add_12_11", 8'd23, 0, 0, 0, 0);
        send8(OP_ADD, 8'hBF, 8'hBF);
        flags8("add_bf_bf", 8'h7E, 1, 1, 0, 0);
        send8(OP_SUB, 8'hBF, 8'hBF);
        flags8("sub_bf_bf", 8'h00, 0, 0, 1, 0);
        send8(OP_NOP, 8'h55, 8'hAA);
        flags8("nop", 8'h00, 0, 0, 1, 0);
        tick();
        chk("drain_valid", 32'(b8.out_valid), 0);

        send8(OP_MUL, 8'd12, 8'd11);
        for (int i = 0; i < 8; i++) begin
            chk("mul_busy", 32'(b8.busy), 1);
            chk("mul_in_ready", 32'(b8.in_ready), 0);
            chk("mul_no_valid", 32'(b8.out_valid), 0);
            tick();
        end
        chk("mul_busy_done", 32'(b8.busy), 0);
        flags8("mul_12_11", 8'h84, 0, 0, 0, 0);

        send8(OP_MUL, 8'h10, 8'h10);
        for (int k = 0; k < 20 && !b8.out_valid; k++) tick();
        flags8("mul_10_10", 8'h00, 1, 1, 1, 0);

        b8.in1 = 8'hF0; b8.in2 = 8'h3C; b8.in_valid = 1'b1;
        b8.alu_op = OP_AND; tick();
        flags8("and", 8'h30, 0, 0, 0, 0);
        b8.alu_op = OP_OR;  tick();
        flags8("or",  8'hFC, 0, 0, 0, 0);
        b8.alu_op = OP_XOR; tick();
        flags8("xor", 8'hCC, 0, 0, 0, 0);
        b8.alu_op = OP_NOT; tick();
        flags8("not", 8'h0F, 0, 0, 0, 0);
        b8.in_valid = 1'b0;
        tick();

        b8.out_ready = 1'b0;
        send8(OP_ADD, 8'd1, 8'd2);
        b8.alu_op = OP_SUB; b8.in1 = 8'd5; b8.in2 = 8'd3; b8.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(b8.out_valid), 1);
            chk("bp_out", 32'(b8.alu_out), 3);
            chk("bp_in_ready", 32'(b8.in_ready), 0);
            tick();
        end
        b8.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(b8.in_ready), 1);
        tick();
        b8.in_valid = 1'b0;
        flags8("bp_sub", 8'd2, 0, 0, 0, 1);
        tick();

        send8(OP_MUL, 8'hFF, 8'hFF);
        tick(); tick(); tick();
        chk("midmul_busy", 32'(b8.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(b8.out_valid), 0);
        chk("arst_busy",  32'(b8.busy), 0);
        chk("arst_out",   32'(b8.alu_out), 0);
        chk("arst_flags", {28'd0, b8.carry, b8.overflow, b8.zero, b8.odd_parity}, 0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("post_rst_no_valid", 32'(b8.out_valid), 0);
        end
        chk("post_rst_in_ready", 32'(b8.in_ready), 1);
        chk("post_rst_busy", 32'(b8.busy), 0);

        b16.alu_op = OP_ADD; b16.in1 = 16'hFFFF; b16.in2 = 16'h0001; b16.in_valid = 1'b1;
        #1;
        chk("w16_in_ready", 32'(b16.in_ready), 1);
        tick();
        b16.in_valid = 1'b0;
        chk("w16_valid", 32'(b16.out_valid), 1);
        chk("w16_out",   32'(b16.alu_out), 0);
        chk("w16_carry", 32'(b16.carry), 1);
        chk("w16_ovf",   32'(b16.overflow), 0);
        chk("w16_zero",  32'(b16.zero), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
